// File: rtl/rx_char_assembler.sv
// -----------------------------------------------------------------------------
// rx_char_assembler
//
// Upstream character assembler of the SpaceWire receive path. It takes one
// recovered bit per bit_valid strobe and hunts for the first NULL (ESC+FCT) to
// gain character alignment. After alignment it frames 4-bit control characters
// and 10-bit data/time-code characters. It also produces the received and
// expected parity of every header.
//
// Strobe semantics: bit_valid is a one-cycle qualifier for bit_d. It has no
// back-pressure and comes at most every second cycle. Every ready_* and
// rx_got_null output is a one-cycle pulse. It is registered on the posedge that
// samples the qualifying bit_valid. The downstream stage must accept it in
// that cycle.
//
// Parameters:
//   NULL_HUNT      1: discard bits until the first NULL is matched
//                  0: assume alignment from the first bit after enable
//
// Optional build macro:
//   RX_ESC_ERROR_EN  adds rx_error_esc. This sticky flag is set when ESC is
//                    followed by EOP, EEP or ESC. It clears on reset or when
//                    rx_enable is low.
//
// Ports:
//   posedge_clk        system clock
//   rx_resetn          asynchronous reset, active low
//   rx_enable          receiver enable; low drops any partial character
//   bit_valid, bit_d   received bit and its strobe
//   rx_locked          alignment achieved
//   rx_got_null        pulse when the first NULL is matched
//   ready_control      pulse: control header (P, flag=1) received
//   ready_data         pulse: data header (P, flag=0) received
//   parity_rec_c/_d    received parity bit of the last control/data header
//   parity_rec_c/d_gen expected parity for that same header
//   ready_control_p_r  pulse: control character complete
//   ready_data_p_r     pulse: data/time-code character complete
//   control_p_r        last control code (4 FCT, 5 EOP, 6 EEP, 7 ESC)
//   control_l_r        control code before control_p_r
//   dta_timec_p        {1'b0, byte} of the last data character
// -----------------------------------------------------------------------------
module rx_char_assembler #(
    parameter bit NULL_HUNT = 1'b1
) (
    input  logic       posedge_clk,
    input  logic       rx_resetn,
    input  logic       rx_enable,
    input  logic       bit_valid,
    input  logic       bit_d,
    output logic       rx_locked,
    output logic       rx_got_null,
    output logic       ready_control,
    output logic       ready_data,
    output logic       parity_rec_c,
    output logic       parity_rec_d,
    output logic       parity_rec_c_gen,
    output logic       parity_rec_d_gen,
    output logic       ready_control_p_r,
    output logic       ready_data_p_r,
    output logic [2:0] control_p_r,
    output logic [2:0] control_l_r,
    output logic [8:0] dta_timec_p
`ifdef RX_ESC_ERROR_EN
    ,
    output logic       rx_error_esc
`endif
);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_HEADER = 2'd1,
        S_CTRL   = 2'd2,
        S_DATA   = 2'd3
    } state_t;

    // State entered after reset and whenever the receiver is disabled.
    localparam state_t IDLE_STATE = NULL_HUNT ? S_HUNT : S_HEADER;

    state_t     state,    state_nxt;
    logic [5:0] hunt_sr,  hunt_sr_nxt;   // six previous bits while hunting
    logic [2:0] bit_cnt,  bit_cnt_nxt;   // bit index inside header/payload
    logic       acc,      acc_nxt;       // XOR of current char payload
    logic       p_bit,    p_bit_nxt;     // parity bit of the current header
    logic [6:0] pay_sr,   pay_sr_nxt;    // payload bits, shifted in from the top
    logic       clr_pend, clr_pend_nxt;  // control_p_r clear after a data char

    logic       locked_nxt, got_null_nxt, rdy_c_nxt, rdy_d_nxt;
    logic       rdy_cp_nxt, rdy_dp_nxt;
    logic       par_c_nxt, par_c_gen_nxt, par_d_nxt, par_d_gen_nxt;
    logic [2:0] ctl_p_nxt, ctl_l_nxt;
    logic [8:0] dta_nxt;
`ifdef RX_ESC_ERROR_EN
    logic       err_nxt;
`endif

    logic [6:0] hunt_win;   // last seven bits including the current one
    logic       par_gen;    // odd parity over previous payload plus flag
    logic [2:0] ctl_code;   // control code completed by the current bit

    assign hunt_win = {hunt_sr, bit_d};
    assign par_gen  = 1'b1 ^ acc ^ bit_d;
    assign ctl_code = {1'b1, pay_sr[6], bit_d};

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge posedge_clk or negedge rx_resetn) begin
        if (!rx_resetn) begin
            state             <= IDLE_STATE;
            hunt_sr           <= '0;
            bit_cnt           <= '0;
            acc               <= 1'b0;
            p_bit             <= 1'b0;
            pay_sr            <= '0;
            clr_pend          <= 1'b0;
            rx_locked         <= 1'b0;
            rx_got_null       <= 1'b0;
            ready_control     <= 1'b0;
            ready_data        <= 1'b0;
            parity_rec_c      <= 1'b0;
            parity_rec_d      <= 1'b0;
            parity_rec_c_gen  <= 1'b0;
            parity_rec_d_gen  <= 1'b0;
            ready_control_p_r <= 1'b0;
            ready_data_p_r    <= 1'b0;
            control_p_r       <= '0;
            control_l_r       <= '0;
            dta_timec_p       <= '0;
`ifdef RX_ESC_ERROR_EN
            rx_error_esc      <= 1'b0;
`endif
        end else begin
            state             <= state_nxt;
            hunt_sr           <= hunt_sr_nxt;
            bit_cnt           <= bit_cnt_nxt;
            acc               <= acc_nxt;
            p_bit             <= p_bit_nxt;
            pay_sr            <= pay_sr_nxt;
            clr_pend          <= clr_pend_nxt;
            rx_locked         <= locked_nxt;
            rx_got_null       <= got_null_nxt;
            ready_control     <= rdy_c_nxt;
            ready_data        <= rdy_d_nxt;
            parity_rec_c      <= par_c_nxt;
            parity_rec_d      <= par_d_nxt;
            parity_rec_c_gen  <= par_c_gen_nxt;
            parity_rec_d_gen  <= par_d_gen_nxt;
            ready_control_p_r <= rdy_cp_nxt;
            ready_data_p_r    <= rdy_dp_nxt;
            control_p_r       <= ctl_p_nxt;
            control_l_r       <= ctl_l_nxt;
            dta_timec_p       <= dta_nxt;
`ifdef RX_ESC_ERROR_EN
            rx_error_esc      <= err_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        hunt_sr_nxt   = hunt_sr;
        bit_cnt_nxt   = bit_cnt;
        acc_nxt       = acc;
        p_bit_nxt     = p_bit;
        pay_sr_nxt    = pay_sr;
        clr_pend_nxt  = 1'b0;
        locked_nxt    = rx_locked;
        got_null_nxt  = 1'b0;
        rdy_c_nxt     = 1'b0;
        rdy_d_nxt     = 1'b0;
        rdy_cp_nxt    = 1'b0;
        rdy_dp_nxt    = 1'b0;
        par_c_nxt     = parity_rec_c;
        par_c_gen_nxt = parity_rec_c_gen;
        par_d_nxt     = parity_rec_d;
        par_d_gen_nxt = parity_rec_d_gen;
        ctl_p_nxt     = control_p_r;
        ctl_l_nxt     = control_l_r;
        dta_nxt       = dta_timec_p;
`ifdef RX_ESC_ERROR_EN
        err_nxt       = rx_error_esc;
`endif

        // control_p_r stays valid during the data pulse so a time-code can be
        // recognised. It is cleared one cycle later. Bit spacing means a
        // control completion can never land in this same cycle.
        if (clr_pend) begin
            ctl_l_nxt = control_p_r;
            ctl_p_nxt = 3'd0;
        end

        if (!rx_enable) begin
            state_nxt   = IDLE_STATE;
            hunt_sr_nxt = '0;
            bit_cnt_nxt = '0;
            acc_nxt     = 1'b0;
            locked_nxt  = 1'b0;
`ifdef RX_ESC_ERROR_EN
            err_nxt     = 1'b0;
`endif
        end else begin
            if (!NULL_HUNT) begin
                locked_nxt = 1'b1;
            end
            if (bit_valid) begin
                case (state)
                    S_HUNT: begin
                        hunt_sr_nxt = hunt_win[5:0];
                        // ESC flag+code, ignored FCT parity, FCT flag+code
                        if (hunt_win[6:4] == 3'b111 && hunt_win[2:0] == 3'b100) begin
                            got_null_nxt = 1'b1;
                            locked_nxt   = 1'b1;
                            ctl_l_nxt    = 3'd7;
                            ctl_p_nxt    = 3'd4;
                            acc_nxt      = 1'b0;
                            bit_cnt_nxt  = '0;
                            hunt_sr_nxt  = '0;
                            state_nxt    = S_HEADER;
                        end
                    end
                    S_HEADER: begin
                        if (bit_cnt == 3'd0) begin
                            p_bit_nxt   = bit_d;
                            bit_cnt_nxt = 3'd1;
                        end else begin
                            bit_cnt_nxt = 3'd0;
                            acc_nxt     = 1'b0;
                            if (bit_d) begin
                                par_c_nxt     = p_bit;
                                par_c_gen_nxt = par_gen;
                                rdy_c_nxt     = 1'b1;
                                state_nxt     = S_CTRL;
                            end else begin
                                par_d_nxt     = p_bit;
                                par_d_gen_nxt = par_gen;
                                rdy_d_nxt     = 1'b1;
                                state_nxt     = S_DATA;
                            end
                        end
                    end
                    S_CTRL: begin
                        pay_sr_nxt = {bit_d, pay_sr[6:1]};
                        acc_nxt    = acc ^ bit_d;
                        if (bit_cnt == 3'd0) begin
                            bit_cnt_nxt = 3'd1;
                        end else begin
                            bit_cnt_nxt = 3'd0;
                            ctl_l_nxt   = control_p_r;
                            ctl_p_nxt   = ctl_code;
                            rdy_cp_nxt  = 1'b1;
                            state_nxt   = S_HEADER;
`ifdef RX_ESC_ERROR_EN
                            if (control_p_r == 3'd7 && ctl_code != 3'd4) begin
                                err_nxt = 1'b1;
                            end
`endif
                        end
                    end
                    S_DATA: begin
                        pay_sr_nxt = {bit_d, pay_sr[6:1]};
                        acc_nxt    = acc ^ bit_d;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt_nxt  = 3'd0;
                            dta_nxt      = {1'b0, bit_d, pay_sr};
                            rdy_dp_nxt   = 1'b1;
                            clr_pend_nxt = 1'b1;
                            state_nxt    = S_HEADER;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 3'd1;
                        end
                    end
                    default: begin
                        state_nxt = IDLE_STATE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_char_assembler.sv
// -----------------------------------------------------------------------------
// tb_rx_char_assembler
//
// This bench drives hand-built SpaceWire bit sequences into rx_char_assembler.
// Expected values are worked out by hand next to each call. A negedge monitor
// counts every pulse and checks completed data bytes against exp_q.
// -----------------------------------------------------------------------------
module tb_rx_char_assembler;

    logic       posedge_clk;
    logic       rx_resetn;
    logic       rx_enable;
    logic       bit_valid;
    logic       bit_d;
    logic       rx_locked;
    logic       rx_got_null;
    logic       ready_control;
    logic       ready_data;
    logic       parity_rec_c;
    logic       parity_rec_d;
    logic       parity_rec_c_gen;
    logic       parity_rec_d_gen;
    logic       ready_control_p_r;
    logic       ready_data_p_r;
    logic [2:0] control_p_r;
    logic [2:0] control_l_r;
    logic [8:0] dta_timec_p;
`ifdef RX_ESC_ERROR_EN
    logic       rx_error_esc;
`endif

    int n_vec = 0;
    int n_err = 0;

    // pulse counters and values captured while pulses are high
    int         n_null = 0;
    int         n_rc   = 0;
    int         n_rd   = 0;
    int         n_rcp  = 0;
    int         n_rdp  = 0;
    logic [2:0] ctl_at_dp = 3'd0;

    logic [8:0] exp_q[$];

    rx_char_assembler dut (
        .posedge_clk       (posedge_clk),
        .rx_resetn         (rx_resetn),
        .rx_enable         (rx_enable),
        .bit_valid         (bit_valid),
        .bit_d             (bit_d),
        .rx_locked         (rx_locked),
        .rx_got_null       (rx_got_null),
        .ready_control     (ready_control),
        .ready_data        (ready_data),
        .parity_rec_c      (parity_rec_c),
        .parity_rec_d      (parity_rec_d),
        .parity_rec_c_gen  (parity_rec_c_gen),
        .parity_rec_d_gen  (parity_rec_d_gen),
        .ready_control_p_r (ready_control_p_r),
        .ready_data_p_r    (ready_data_p_r),
        .control_p_r       (control_p_r),
        .control_l_r       (control_l_r),
        .dta_timec_p       (dta_timec_p)
`ifdef RX_ESC_ERROR_EN
        ,
        .rx_error_esc      (rx_error_esc)
`endif
    );

    // ---------------- clock / reset ----------------
    initial posedge_clk = 1'b0;
    always #5 posedge_clk = ~posedge_clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge posedge_clk) begin
        if (rx_resetn) begin
            if (rx_got_null)       n_null++;
            if (ready_control)     n_rc++;
            if (ready_data)        n_rd++;
            if (ready_control_p_r) n_rcp++;
            if (ready_data_p_r) begin
                n_rdp++;
                ctl_at_dp = control_p_r;
                if (exp_q.size() == 0)
                    check("dta_expected_queue", 32'(exp_q.size()), 32'd1);
                else
                    check("dta_timec_p", 32'(dta_timec_p), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- drivers ----------------
    // One bit every three cycles; the task returns one idle cycle after the
    // sampling edge, so one-cycle-later effects are already visible.
    task automatic send_bit(input logic b);
        @(negedge posedge_clk);
        bit_valid = 1'b1;
        bit_d     = b;
        @(negedge posedge_clk);
        bit_valid = 1'b0;
        bit_d     = 1'b0;
        @(negedge posedge_clk);
    endtask

    task automatic send_hdr(input logic p, input logic flag);
        send_bit(p);
        send_bit(flag);
    endtask

    task automatic send_ctl(input logic [1:0] code);
        send_bit(code[1]);
        send_bit(code[0]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_q.push_back({1'b0, b});
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_null();
        logic [7:0] nb;
        nb = 8'b0111_1100;   // ESC (P0,1,1,1) then FCT (P1,1,0,0), first bit at [7]
        for (int i = 7; i >= 0; i--) send_bit(nb[i]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] junk;
        rx_resetn = 1'b0;
        rx_enable = 1'b0;
        bit_valid = 1'b0;
        bit_d     = 1'b0;
        repeat (3) @(negedge posedge_clk);

        // reset state
        check("rst_locked",  32'(rx_locked),   32'd0);
        check("rst_null",    32'(rx_got_null), 32'd0);
        check("rst_ctl_p",   32'(control_p_r), 32'd0);
        check("rst_ctl_l",   32'(control_l_r), 32'd0);
        check("rst_dta",     32'(dta_timec_p), 32'd0);
        check("rst_par",     32'({parity_rec_c, parity_rec_c_gen, parity_rec_d, parity_rec_d_gen}), 32'd0);
        check("rst_pulses",  32'({ready_control, ready_data, ready_control_p_r, ready_data_p_r}), 32'd0);

        rx_resetn = 1'b1;
        // bits while disabled are ignored
        send_bit(1'b1);
        send_bit(1'b1);
        check("dis_locked", 32'(rx_locked), 32'd0);

        // garbage then NULL; no 7-bit window before the final bit matches
        rx_enable = 1'b1;
        junk = 8'b1010_0000;
        for (int i = 7; i >= 5; i--) send_bit(junk[i]);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        check("pre_null_locked", 32'(rx_locked), 32'd0);
        check("pre_null_count",  32'(n_null),    32'd0);
        send_bit(1'b0);
        check("null_count",  32'(n_null),      32'd1);
        check("null_locked", 32'(rx_locked),   32'd1);
        check("null_ctl_p",  32'(control_p_r), 32'd4);
        check("null_ctl_l",  32'(control_l_r), 32'd7);
        check("null_no_rdy", 32'(n_rc + n_rd + n_rcp + n_rdp), 32'd0);

        // data 0xA5, P = 1^0^0 = 1
        send_hdr(1'b1, 1'b0);
        check("d1_rd",    32'(n_rd),             32'd1);
        check("d1_prd",   32'(parity_rec_d),     32'd1);
        check("d1_prdg",  32'(parity_rec_d_gen), 32'd1);
        send_byte(8'hA5);
        check("d1_rdp",   32'(n_rdp),       32'd1);
        check("d1_ctl_dp",32'(ctl_at_dp),   32'd4);
        check("d1_ctl_p", 32'(control_p_r), 32'd0);
        check("d1_ctl_l", 32'(control_l_r), 32'd4);

        // EOP, P = 1^0^1 = 0
        send_hdr(1'b0, 1'b1);
        check("eop_rc",   32'(n_rc),             32'd1);
        check("eop_prc",  32'(parity_rec_c),     32'd0);
        check("eop_prcg", 32'(parity_rec_c_gen), 32'd0);
        send_ctl(2'b01);
        check("eop_rcp",  32'(n_rcp),       32'd1);
        check("eop_ctl_p",32'(control_p_r), 32'd5);
        check("eop_ctl_l",32'(control_l_r), 32'd0);

        // ESC (P = 1^1^1 = 1) then time-code 0x3F (P = 1^0^0 = 1)
        send_hdr(1'b1, 1'b1);
        check("esc_prcg", 32'(parity_rec_c_gen), 32'd1);
        send_ctl(2'b11);
        check("esc_ctl_p",32'(control_p_r), 32'd7);
        check("esc_ctl_l",32'(control_l_r), 32'd5);
        send_hdr(1'b1, 1'b0);
        send_byte(8'h3F);
        check("tc_ctl_dp",32'(ctl_at_dp),   32'd7);
        check("tc_ctl_p", 32'(control_p_r), 32'd0);
        check("tc_ctl_l", 32'(control_l_r), 32'd7);

        // FCT with wrong parity: correct P = 1^0^1 = 0, send 1
        send_hdr(1'b1, 1'b1);
        check("fct_prc",  32'(parity_rec_c),     32'd1);
        check("fct_prcg", 32'(parity_rec_c_gen), 32'd0);
        send_ctl(2'b00);
        check("fct_rcp",  32'(n_rcp),       32'd3);
        check("fct_ctl_p",32'(control_p_r), 32'd4);

        // data 0x80, P = 1^0^0 = 1; control parity outputs hold
        send_hdr(1'b1, 1'b0);
        check("d3_prc_hold", 32'(parity_rec_c), 32'd1);
        send_byte(8'h80);

        // data header P = 1^1^0 = 0, then drop enable after 4 payload bits
        send_hdr(1'b0, 1'b0);
        check("drop_prd",  32'(parity_rec_d),     32'd0);
        check("drop_prdg", 32'(parity_rec_d_gen), 32'd0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        rx_enable = 1'b0;
        send_bit(1'b1);
        check("drop_locked", 32'(rx_locked),   32'd0);
        check("drop_rdp",    32'(n_rdp),       32'd3);
        check("drop_dta",    32'(dta_timec_p), 32'h080);
        check("drop_prd_hold", 32'(parity_rec_d), 32'd0);

        // re-enable: the rest of the dropped byte is hunted through, then NULL
        rx_enable = 1'b1;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        check("rehunt_rdp", 32'(n_rdp),     32'd3);
        check("rehunt_lck", 32'(rx_locked), 32'd0);
        send_null();
        check("renull_count", 32'(n_null),      32'd2);
        check("renull_lock",  32'(rx_locked),   32'd1);
        check("renull_ctl_l", 32'(control_l_r), 32'd7);

        // ESC (P = 1^0^1 = 0) then EEP (P = 1^0^1 = 0)
`ifdef RX_ESC_ERROR_EN
        check("err_before", 32'(rx_error_esc), 32'd0);
`endif
        send_hdr(1'b0, 1'b1);
        send_ctl(2'b11);
        send_hdr(1'b0, 1'b1);
        check("eep_prcg", 32'(parity_rec_c_gen), 32'd0);
        send_ctl(2'b10);
        check("eep_ctl_p", 32'(control_p_r), 32'd6);
        check("eep_ctl_l", 32'(control_l_r), 32'd7);
`ifdef RX_ESC_ERROR_EN
        check("err_esc_eep", 32'(rx_error_esc), 32'd1);
`endif

        // totals
        check("tot_rc",  32'(n_rc),  32'd5);
        check("tot_rd",  32'(n_rd),  32'd4);
        check("tot_rcp", 32'(n_rcp), 32'd5);
        check("tot_rdp", 32'(n_rdp), 32'd3);
        check("exp_q_left", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
